// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the controller state encoding and a constant clog2 helper used
// to size the bit counter, so every serial block agrees on both.
package serial_arith_pkg;

    // Controller states for a serial operation: waiting, shifting one bit
    // per clock, and the single result-valid cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Ceiling log2 usable in constant expressions (parameter sizing).
    // clog2(1) = 0, clog2(8) = 3, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_serial_addsub_if.sv
// Request/result bundle for the bit-serial add/subtract unit.
// Signals:
//   start, sub, a, b  : request issued by the controller (master)
//   busy, done        : progress flags returned by the unit (slave)
//   sum, cout, ovf    : registered result, carry/no-borrow, signed overflow
interface bit_serial_addsub_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // The controller drives requests and observes results.
    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    // The arithmetic unit consumes requests and produces results.
    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_fa_cell.sv
// One full-adder cell with its carry flop, the arithmetic core of the
// bit-serial unit.
// Ports:
//   clk, clr_n    : clock and asynchronous active-low clear of the carry
//   load_i        : load carry_init_i as the starting carry (synchronous)
//   carry_init_i  : initial carry (1 for subtraction, providing the +1)
//   en_i          : advance the carry by one bit position
//   a_i, b_i      : current operand bits
//   sum_o         : sum bit for the current position
//   cout_o        : carry out of the current position
//   cin_o         : carry into the current position (needed for overflow)
module serial_fa_cell (
    input  logic clk,
    input  logic clr_n,
    input  logic load_i,
    input  logic carry_init_i,
    input  logic en_i,
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic cout_o,
    output logic cin_o
);

    logic carry_q;
    logic carry_d;

    assign cin_o  = carry_q;
    assign sum_o  = a_i ^ b_i ^ carry_q;
    assign cout_o = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);

    // Load takes priority so a new operation can be accepted in the same
    // cycle the previous one finishes.
    always_comb begin
        carry_d = carry_q;
        if (load_i) begin
            carry_d = carry_init_i;
        end else if (en_i) begin
            carry_d = cout_o;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor behind a start/busy/done handshake.
// Operands are shifted out LSB first through a single full-adder cell;
// the result appears WIDTH clocks after the accepting edge with a
// one-cycle done pulse, and stays stable until the next completion.
// Ports:
//   clk    : rising-edge clock
//   clr_n  : asynchronous active-low reset; abandons any operation
//   bus    : slave side of bit_serial_addsub_if
//            (start/sub/a/b in, busy/done/sum/cout/ovf out, all registered)
module bit_serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    bit_serial_addsub_if.slave   bus
);

    localparam int CW = clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             load;
    logic             shiftEn;
    logic             lastBit;
    logic             faSum;
    logic             faCout;
    logic             faCin;
    logic [WIDTH-1:0] accShift;

    serial_fa_cell u_fa (
        .clk          (clk),
        .clr_n        (clr_n),
        .load_i       (load),
        .carry_init_i (bus.sub),
        .en_i         (shiftEn),
        .a_i          (opA_q[0]),
        .b_i          (opB_q[0]),
        .sum_o        (faSum),
        .cout_o       (faCout),
        .cin_o        (faCin)
    );

    // The new sum bit enters at the MSB, so after WIDTH shifts the LSB
    // computed first has reached bit 0. A one-bit accumulator is just the bit.
    generate
        if (WIDTH == 1) begin : gNarrowAcc
            assign accShift = faSum;
        end else begin : gWideAcc
            assign accShift = {faSum, acc_q[WIDTH-1:1]};
        end
    endgenerate

    assign lastBit = (count_q == CW'(WIDTH - 1));

    // Next-state and datapath control. Accept is possible in IDLE and in
    // DONE so back-to-back requests lose no cycle. Subtraction is a + ~b + 1,
    // with the +1 supplied as the initial carry. Result registers are only
    // written on the last shift, so the previous result stays visible.
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        acc_d   = acc_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        shiftEn = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    opA_d   = bus.a;
                    opB_d   = bus.sub ? ~bus.b : bus.b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                shiftEn = 1'b1;
                opA_d   = opA_q >> 1;
                opB_d   = opB_q >> 1;
                acc_d   = accShift;
                count_d = count_q + CW'(1);
                if (lastBit) begin
                    sum_d   = accShift;
                    cout_d  = faCout;
                    ovf_d   = faCin ^ faCout;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State, operand, accumulator and result registers. busy and done are
    // registered copies of the next state so every output is a flop.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Self-checking bench for bit_serial_addsub at WIDTH 8, 16 and 1.
// Expected results come from plain integer arithmetic in refModel.
module tb_bit_serial_addsub;

    logic clk;
    logic clr_n;

    int compared;
    int mismatched;

    bit_serial_addsub_if #(.WIDTH(8))  if8  ();
    bit_serial_addsub_if #(.WIDTH(16)) if16 ();
    bit_serial_addsub_if #(.WIDTH(1))  if1  ();

    bit_serial_addsub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (if8.slave)
    );

    bit_serial_addsub #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (if16.slave)
    );

    bit_serial_addsub #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (if1.slave)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Arithmetic reference: unsigned sum/difference, carry or no-borrow, and
    // signed overflow from operand and result sign bits.
    function automatic void refModel(input int w, input bit [63:0] av, input bit [63:0] bv,
                                     input bit sv, output bit [63:0] s,
                                     output bit c, output bit v);
        bit [63:0] mask;
        bit [63:0] full;
        bit        sa, sb, ss;
        mask = (64'd1 << w) - 64'd1;
        av   = av & mask;
        bv   = bv & mask;
        if (!sv) begin
            full = av + bv;
            s    = full & mask;
            c    = full[w];
        end else begin
            s = (av - bv) & mask;
            c = (av >= bv);
        end
        sa = av[w-1];
        sb = bv[w-1];
        ss = s[w-1];
        v  = sv ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    endfunction

    // Drives the request side of the selected instance.
    task automatic applyStimulus(input int which, input bit st, input bit [63:0] av,
                                 input bit [63:0] bv, input bit sv);
        case (which)
            0: begin
                if8.start = st;  if8.sub = sv;  if8.a = av[7:0];   if8.b = bv[7:0];
            end
            1: begin
                if16.start = st; if16.sub = sv; if16.a = av[15:0]; if16.b = bv[15:0];
            end
            default: begin
                if1.start = st;  if1.sub = sv;  if1.a = av[0];     if1.b = bv[0];
            end
        endcase
    endtask

    // Reads the result side of the selected instance, zero-extended.
    task automatic readOut(input int which, output bit bz, output bit dn,
                           output bit [63:0] s, output bit c, output bit v);
        case (which)
            0: begin
                bz = if8.busy;  dn = if8.done;  s = 64'(if8.sum);  c = if8.cout;  v = if8.ovf;
            end
            1: begin
                bz = if16.busy; dn = if16.done; s = 64'(if16.sum); c = if16.cout; v = if16.ovf;
            end
            default: begin
                bz = if1.busy;  dn = if1.done;  s = 64'(if1.sum);  c = if1.cout;  v = if1.ovf;
            end
        endcase
    endtask

    // One complete checked transaction: accept, shift, done pulse, result.
    task automatic runOp(input int which, input int w, input bit [63:0] av,
                         input bit [63:0] bv, input bit sv, input string tag);
        bit [63:0] expS, prevS, s;
        bit        expC, expV, bz, dn, c, v;
        int        edges, busyCnt;
        refModel(w, av, bv, sv, expS, expC, expV);
        @(negedge clk);
        readOut(which, bz, dn, prevS, c, v);
        applyStimulus(which, 1'b1, av, bv, sv);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(which, 1'b0, av, bv, sv);
        readOut(which, bz, dn, s, c, v);
        checkOutput({tag, "/busyAfterAccept"}, 64'(bz), 64'd1);
        checkOutput({tag, "/sumHeld"}, s, prevS);
        edges   = 0;
        busyCnt = 0;
        while (!dn && edges < 4 * w + 8) begin
            if (bz) busyCnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
            readOut(which, bz, dn, s, c, v);
        end
        checkOutput({tag, "/latency"}, 64'(edges), 64'(w));
        checkOutput({tag, "/busyCycles"}, 64'(busyCnt), 64'(w));
        checkOutput({tag, "/busyAtDone"}, 64'(bz), 64'd0);
        checkOutput({tag, "/sum"}, s, expS);
        checkOutput({tag, "/cout"}, 64'(c), 64'(expC));
        checkOutput({tag, "/ovf"}, 64'(v), 64'(expV));
        @(negedge clk);
        readOut(which, bz, dn, s, c, v);
        checkOutput({tag, "/donePulse"}, 64'(dn), 64'd0);
    endtask

    // Waits (bounded) until the 8-bit instance raises done; returns edges.
    task automatic waitDone8(output int edges);
        edges = 0;
        while (!if8.done && edges < 64) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  edges;
        bit  sawDone;
        bit [63:0] ra, rb;

        compared   = 0;
        mismatched = 0;
        clr_n      = 1'b0;
        applyStimulus(0, 1'b0, 64'd0, 64'd0, 1'b0);
        applyStimulus(1, 1'b0, 64'd0, 64'd0, 1'b0);
        applyStimulus(2, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (2) @(negedge clk);

        checkOutput("reset/busy", 64'(if8.busy), 64'd0);
        checkOutput("reset/done", 64'(if8.done), 64'd0);
        checkOutput("reset/sum",  64'(if8.sum),  64'd0);
        checkOutput("reset/cout", 64'(if8.cout), 64'd0);
        checkOutput("reset/ovf",  64'(if8.ovf),  64'd0);
        clr_n = 1'b1;

        // Directed cases at WIDTH=8.
        runOp(0, 8, 64'h35, 64'h4A, 1'b0, "add35_4A");
        runOp(0, 8, 64'hFF, 64'h01, 1'b0, "addFF_01");
        runOp(0, 8, 64'h7F, 64'h01, 1'b0, "add7F_01");
        runOp(0, 8, 64'h50, 64'h70, 1'b1, "sub50_70");
        runOp(0, 8, 64'h80, 64'h01, 1'b1, "sub80_01");

        // A start pulse while busy is ignored, then a back-to-back accept.
        @(negedge clk);
        applyStimulus(0, 1'b1, 64'h35, 64'h4A, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 1'b0, 64'h35, 64'h4A, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        applyStimulus(0, 1'b1, 64'h11, 64'h22, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 1'b0, 64'h11, 64'h22, 1'b0);
        waitDone8(edges);
        checkOutput("ignore/done", 64'(if8.done), 64'd1);
        checkOutput("ignore/sum", 64'(if8.sum), 64'h7F);
        applyStimulus(0, 1'b1, 64'h10, 64'h20, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 1'b0, 64'h10, 64'h20, 1'b0);
        edges = 1;
        begin
            int more;
            waitDone8(more);
            edges = edges + more;
        end
        checkOutput("b2b/spacing", 64'(edges), 64'd9);
        checkOutput("b2b/sum", 64'(if8.sum), 64'h30);

        // Reset during the fourth shift cycle abandons the operation.
        @(negedge clk);
        @(negedge clk);
        applyStimulus(0, 1'b1, 64'h12, 64'h34, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 1'b0, 64'h12, 64'h34, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        clr_n = 1'b0;
        #1;
        checkOutput("midReset/busy", 64'(if8.busy), 64'd0);
        checkOutput("midReset/done", 64'(if8.done), 64'd0);
        checkOutput("midReset/sum",  64'(if8.sum),  64'd0);
        checkOutput("midReset/cout", 64'(if8.cout), 64'd0);
        checkOutput("midReset/ovf",  64'(if8.ovf),  64'd0);
        repeat (2) @(negedge clk);
        clr_n   = 1'b1;
        sawDone = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (if8.done) sawDone = 1'b1;
        end
        checkOutput("midReset/noDone", 64'(sawDone), 64'd0);
        runOp(0, 8, 64'h01, 64'h02, 1'b0, "postReset");

        // Other widths.
        runOp(1, 16, 64'h0000, 64'h0001, 1'b1, "w16sub0_1");
        runOp(2, 1, 64'd1, 64'd1, 1'b0, "w1add1_1");

        // Randomized operations on all three widths.
        for (int i = 0; i < 30; i++) begin
            ra = 64'($urandom_range(0, 255));
            rb = 64'($urandom_range(0, 255));
            runOp(0, 8, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd8_%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            ra = 64'($urandom_range(0, 65535));
            rb = 64'($urandom_range(0, 65535));
            runOp(1, 16, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd16_%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            ra = 64'($urandom_range(0, 1));
            rb = 64'($urandom_range(0, 1));
            runOp(2, 1, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd1_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bit_serial_addsub.md
Name: bit_serial_addsub

Overview:
- Parametrised, handshaked successor to the team's 8-bit bit-serial adder.
- Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, with a single full-adder cell and a carry flop.
- Reports carry/borrow and signed overflow.
- Sits behind a start/busy/done handshake, so a controller can issue back-to-back operations without tracking cycle counts.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  input  1  single clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while an operation is shifting.
- done  output  1  one-cycle pulse when a result is valid.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  add: carry out; sub: 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement overflow of the result.

Behaviour:
- Reset (clr_n=0, asynchronous, takes effect immediately):
  - state=IDLE; busy, done, sum, cout, ovf, count and carry all 0.
  - Operand shift registers cleared.
  - Reset mid-operation abandons it; no done pulse is issued.
- Accept:
  - start=1 while busy=0 (state IDLE or DONE) is accepted at that edge, E0.
  - Load: opA<=a; opB<=(sub ? ~b : b); carry<=sub; count<=0; state<=SHIFT.
  - start while busy=1 is ignored; the operation in flight is unaffected.
- SHIFT (WIDTH cycles):
  - Each edge: bit = opA[0]^opB[0]^carry; carry <= majority(opA[0],opB[0],carry).
  - opA, opB shift right one place; bit shifts into the MSB of the internal accumulator.
  - count <= count+1.
  - On the edge where count==WIDTH-1 (edge E0+WIDTH):
    - sum <= final accumulator value, including this bit.
    - cout <= final carry.
    - ovf <= carry into MSB XOR carry out of MSB.
    - state <= DONE.
- DONE (one cycle):
  - done=1 and busy=0.
  - sum, cout and ovf are valid and remain stable until the next completion or reset.
  - Next edge: state <= IDLE, unless start=1, in which case a new accept occurs (back-to-back; throughput one result per WIDTH+1 cycles).
- busy is 1 exactly for states SHIFT: from after E0 up to, but not including, the DONE cycle.
- Latency: done rises WIDTH edges after the accept edge.
- sum, cout and ovf never change during SHIFT; the previous result stays visible.
- WIDTH=1: a single SHIFT cycle; ovf = carry-in XOR carry-out of bit 0.
- count width is clog2(WIDTH)+1, so count never wraps within an operation.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package/include serial_arith_pkg holds:
  - FSM state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - The clog2 constant function used for the count width.
- One natural sub-module: serial_fa_cell.
  - Full adder plus carry flop with async active-low clear.
  - Synchronous load of the initial carry.
  - Exposes sum bit, carry-out and carry-in (carry-in is needed for ovf).
- Operand shift registers and FSM stay in the top.

Test Plan:
1. WIDTH=8, add a=0x35 b=0x4A:
   - busy high 8 cycles, done 8 edges after accept.
   - sum=0x7F, cout=0, ovf=0.
2. Add a=0xFF b=0x01 -> sum=0x00, cout=1, ovf=0. Add a=0x7F b=0x01 -> sum=0x80, cout=0, ovf=1.
3. Subtract a=0x50 b=0x70 -> sum=0xE0, cout=0 (borrow), ovf=0. Subtract a=0x80 b=0x01 -> sum=0x7F, cout=1, ovf=1.
4. Pulse start with a=0x11 b=0x22 at cycle 3 of a busy 0x35+0x4A operation:
   - Ignored; result is 0x7F.
   - Then start held high through DONE: second operation accepted back-to-back, done pulses exactly 9 cycles apart.
5. Drop clr_n during cycle 4 of SHIFT:
   - busy, done, sum, cout and ovf are 0 immediately.
   - No done pulse.
   - A following 0x01+0x02 gives sum=0x03.
6. WIDTH=16, subtract a=0x0000 b=0x0001:
   - sum=0xFFFF, cout=0, ovf=0, done after 16 cycles.
   - WIDTH=1, add 1+1: sum=0, cout=1, ovf=1.
